// File: rtl/beehive_noc_hdr_builder.sv
// Data-NoC header generator and framer: builds a multi-flit header from a
// request, then forwards exactly the announced number of body flits.
module beehive_noc_hdr_builder #(
    parameter int         NOC_DATA_W = 512,
    parameter int         HDR_CORE_W = 220,
    parameter logic [3:0] SRC_FBITS  = 4'b1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            src_x,
    input  logic [7:0]            src_y,
    input  logic                  req_val,
    output logic                  req_rdy,
    input  logic [7:0]            req_dst_x,
    input  logic [7:0]            req_dst_y,
    input  logic [3:0]            req_dst_fbits,
    input  logic [7:0]            req_msg_type,
    input  logic [7:0]            req_meta_flits,
    input  logic [15:0]           req_payload_bytes,
    input  logic                  data_in_val,
    input  logic [NOC_DATA_W-1:0] data_in_data,
    input  logic                  data_in_last,
    output logic                  data_in_rdy,
    output logic                  noc_out_val,
    output logic [NOC_DATA_W-1:0] noc_out_data,
    input  logic                  noc_out_rdy,
    output logic                  err_oversize,
    output logic                  err_framing
);

    localparam int BPF       = NOC_DATA_W / 8;
    localparam int HDR_FLITS = (HDR_CORE_W + NOC_DATA_W - 1) / NOC_DATA_W;
    localparam int HDR_IMG_W = HDR_FLITS * NOC_DATA_W;
    localparam int PAD_W     = HDR_IMG_W - HDR_CORE_W;
    localparam int IDX_W     = (HDR_FLITS > 1) ? $clog2(HDR_FLITS) : 1;

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       hdr_idx;
    logic [7:0]             body_cnt;
    logic [63:0]            ts_cnt;
    logic [47:0]            pkt_num;
    logic [HDR_IMG_W-1:0]   hdr_img;

    logic [16:0]            pay_flits;
    logic [16:0]            body_len;
    logic [17:0]            msg_len;
    logic                   oversize;
    logic [HDR_CORE_W-1:0]  hdr_core;
    logic [HDR_IMG_W-1:0]   hdr_core_img;
    logic                   req_hs, hdr_hs, body_hs, body_final;

    // Ceiling division of a byte count into whole flits; zero bytes -> zero flits.
    function automatic logic [16:0] ceil_flits(input logic [15:0] bytes);
        logic [16:0] sum;
        sum = {1'b0, bytes} + 17'(BPF - 1);
        return sum / 17'(BPF);
    endfunction

    assign pay_flits = ceil_flits(req_payload_bytes);
    assign body_len  = 17'(req_meta_flits) + pay_flits;
    assign msg_len   = 18'(HDR_FLITS - 1) + {1'b0, body_len};
    assign oversize  = (msg_len > 18'd255);

    assign hdr_core = {14'd0, req_dst_x, req_dst_y, req_dst_fbits, msg_len[7:0],
                       req_msg_type, 14'd0, src_x, src_y, SRC_FBITS,
                       req_meta_flits, src_x, src_y, pkt_num, ts_cnt};
    // Core is left-justified so flit 0 carries the routing fields.
    assign hdr_core_img = HDR_IMG_W'(hdr_core) << PAD_W;

    assign req_hs     = req_val && req_rdy;
    assign hdr_hs     = (state == HDR) && noc_out_rdy;
    assign body_hs    = (state == BODY) && data_in_val && noc_out_rdy;
    assign body_final = (body_cnt == 8'd1);

    always_comb begin
        state_nxt    = state;
        req_rdy      = 1'b0;
        data_in_rdy  = 1'b0;
        noc_out_val  = 1'b0;
        noc_out_data = '0;
        case (state)
            IDLE: begin
                req_rdy = !rst;
                if (req_val && !rst && !oversize)
                    state_nxt = HDR;
            end
            HDR: begin
                noc_out_val  = 1'b1;
                noc_out_data = hdr_img[HDR_IMG_W-1 -: NOC_DATA_W];
                if (noc_out_rdy && (hdr_idx == IDX_W'(HDR_FLITS - 1)))
                    state_nxt = (body_cnt != 8'd0) ? BODY : IDLE;
            end
            BODY: begin
                noc_out_val  = data_in_val;
                noc_out_data = data_in_data;
                data_in_rdy  = noc_out_rdy;
                if (body_hs && body_final)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hdr_idx      <= '0;
            body_cnt     <= 8'd0;
            ts_cnt       <= 64'd0;
            pkt_num      <= 48'd0;
            err_oversize <= 1'b0;
            err_framing  <= 1'b0;
        end else begin
            state        <= state_nxt;
            ts_cnt       <= ts_cnt + 64'd1;
            err_oversize <= req_hs && oversize;
            // The marker is only checked; the announced count always governs framing.
            err_framing  <= body_hs && (data_in_last != body_final);
            if (req_hs && !oversize) begin
                hdr_idx  <= '0;
                body_cnt <= body_len[7:0];
                pkt_num  <= pkt_num + 48'd1;
            end else if (hdr_hs) begin
                hdr_idx  <= hdr_idx + 1'b1;
            end else if (body_hs) begin
                body_cnt <= body_cnt - 8'd1;
            end
        end
    end

    // Header image shifts up one flit per accepted header beat.
    always_ff @(posedge clk) begin
        if (req_hs && !oversize)
            hdr_img <= hdr_core_img;
        else if (hdr_hs)
            hdr_img <= hdr_img << NOC_DATA_W;
    end

endmodule

// File: tb/tb_beehive_noc_hdr_builder.sv
// Scoreboard bench for beehive_noc_hdr_builder at a 128-bit flit width
// (two header flits), with randomized requests, bodies and backpressure.
module tb_beehive_noc_hdr_builder;

    localparam int W   = 128;
    localparam int BPF = W / 8;
    localparam int HF  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    src_x = 8'd0, src_y = 8'd0;
    logic          req_val = 1'b0;
    logic          req_rdy;
    logic [7:0]    req_dst_x = 8'd0, req_dst_y = 8'd0;
    logic [3:0]    req_dst_fbits = 4'd0;
    logic [7:0]    req_msg_type = 8'd0, req_meta_flits = 8'd0;
    logic [15:0]   req_payload_bytes = 16'd0;
    logic          data_in_val = 1'b0;
    logic [W-1:0]  data_in_data = '0;
    logic          data_in_last = 1'b0;
    logic          data_in_rdy;
    logic          noc_out_val;
    logic [W-1:0]  noc_out_data;
    logic          noc_out_rdy = 1'b1;
    logic          err_oversize, err_framing;

    beehive_noc_hdr_builder #(.NOC_DATA_W(W)) dut (
        .clk(clk), .rst(rst), .src_x(src_x), .src_y(src_y),
        .req_val(req_val), .req_rdy(req_rdy),
        .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_dst_fbits(req_dst_fbits),
        .req_msg_type(req_msg_type), .req_meta_flits(req_meta_flits),
        .req_payload_bytes(req_payload_bytes),
        .data_in_val(data_in_val), .data_in_data(data_in_data),
        .data_in_last(data_in_last), .data_in_rdy(data_in_rdy),
        .noc_out_val(noc_out_val), .noc_out_data(noc_out_data), .noc_out_rdy(noc_out_rdy),
        .err_oversize(err_oversize), .err_framing(err_framing)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int           n_tests = 0, n_fail = 0;
    int           exp_ovs = 0, exp_frm = 0, seen_ovs = 0, seen_frm = 0;
    logic [47:0]  m_pkt = 48'd0;
    logic [63:0]  cyc;
    int           bp_mode = 0;

    // Cycles elapsed since reset release: the value the timestamp must carry.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 64'd0;
        else     cyc <= cyc + 64'd1;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                1:       noc_out_rdy = ~noc_out_rdy;
                2:       noc_out_rdy = 1'($urandom_range(0, 1));
                default: noc_out_rdy = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every NoC handshake and checks hold-under-stall.
    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_val", 128'(noc_out_val), 128'd1);
                    chk("hold_data", 128'(noc_out_data), 128'(prev_data));
                end
                if (noc_out_val && noc_out_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_flit: got %h expected none", noc_out_data);
                    end else begin
                        chk("flit", 128'(noc_out_data), 128'(exp_q.pop_front()));
                    end
                end
                prev_stall = noc_out_val && !noc_out_rdy;
                prev_data  = noc_out_data;
                if (err_oversize) seen_ovs++;
                if (err_framing)  seen_frm++;
            end
        end
    end

    // last_mode: 0 correct marker, 1 marker on first and final flit, 2 random.
    // stop_after >= 0 abandons the body after that many flits.
    task automatic send(input logic [7:0] dx, input logic [7:0] dy, input logic [3:0] fb,
                        input logic [7:0] mt, input logic [7:0] mm, input logic [15:0] pb,
                        input int last_mode, input int stop_after);
        logic [63:0]  ts;
        logic [7:0]   ml8;
        logic [219:0] core;
        logic [255:0] img;
        logic         lst;
        int           pf, body, ml;
        bit           got;
        @(posedge clk); #1;
        req_dst_x = dx; req_dst_y = dy; req_dst_fbits = fb;
        req_msg_type = mt; req_meta_flits = mm; req_payload_bytes = pb;
        req_val = 1'b1;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_rdy) begin got = 1; break; end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL req_timeout: got req_rdy=0 expected 1");
            req_val = 1'b0;
            return;
        end
        ts = cyc;
        @(posedge clk); #1;
        req_val = 1'b0;
        pf   = (int'(pb) + BPF - 1) / BPF;
        body = int'(mm) + pf;
        ml   = HF - 1 + body;
        if (ml > 255) begin
            exp_ovs++;
            return;
        end
        ml8  = 8'(ml);
        core = {14'd0, dx, dy, fb, ml8, mt, 14'd0, src_x, src_y, 4'b1000,
                mm, src_x, src_y, m_pkt, ts};
        img  = {core, 36'd0};
        exp_q.push_back(img[255:128]);
        exp_q.push_back(img[127:0]);
        m_pkt++;
        for (int i = 0; i < body; i++) begin
            if (stop_after >= 0 && i >= stop_after) return;
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            case (last_mode)
                1:       lst = (i == 0) || (i == body - 1);
                2:       lst = 1'($urandom_range(0, 1));
                default: lst = (i == body - 1);
            endcase
            if (lst != (i == body - 1)) exp_frm++;
            data_in_data = {$urandom, $urandom, $urandom, $urandom};
            data_in_last = lst;
            data_in_val  = 1'b1;
            exp_q.push_back(data_in_data);
            got = 0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (data_in_rdy) begin got = 1; break; end
            end
            if (!got) begin
                n_tests++; n_fail++;
                $display("FAIL body_timeout: got data_in_rdy=0 expected 1");
            end
            @(posedge clk); #1;
            data_in_val  = 1'b0;
            data_in_last = 1'b0;
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input logic rdy_exp);
        chk({tag, "_req_rdy"},     128'(req_rdy), 128'(rdy_exp));
        chk({tag, "_data_in_rdy"}, 128'(data_in_rdy), 128'd0);
        chk({tag, "_noc_val"},     128'(noc_out_val), 128'd0);
        chk({tag, "_noc_data"},    128'(noc_out_data), 128'd0);
        chk({tag, "_err_ovs"},     128'(err_oversize), 128'd0);
        chk({tag, "_err_frm"},     128'(err_framing), 128'd0);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset", 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("idle", 1'b1);

        // Header plus metadata/payload body, correct last marker.
        send(8'd2, 8'd3, 4'd0, 8'd3, 8'd1, 16'd100, 0, -1);
        // Header-only messages; the second carries the next packet number.
        send(8'd4, 8'd5, 4'd2, 8'd7, 8'd0, 16'd0, 0, -1);
        send(8'd6, 8'd1, 4'd1, 8'd9, 8'd0, 16'd0, 0, -1);

        src_x = 8'h15; src_y = 8'h2A;
        bp_mode = 1;
        send(8'd9, 8'd8, 4'd3, 8'd1, 8'd2, 16'd33, 0, -1);
        bp_mode = 0;

        // Oversized request is dropped with a single error pulse.
        base = seen_ovs;
        send(8'd1, 8'd1, 4'd0, 8'd0, 8'd0, 16'd65535, 0, -1);
        repeat (3) @(negedge clk);
        chk("oversize_pulse", 128'(seen_ovs - base), 128'd1);
        send(8'd3, 8'd3, 4'd0, 8'd2, 8'd0, 16'd16, 0, -1);

        // Early last marker on a 3-flit body: one framing pulse, all flits forwarded.
        base = seen_frm;
        send(8'd7, 8'd7, 4'd5, 8'd4, 8'd3, 16'd0, 1, -1);
        repeat (3) @(negedge clk);
        chk("framing_pulse", 128'(seen_frm - base), 128'd1);

        bp_mode = 2;
        for (int n = 0; n < 20; n++) begin
            logic [7:0] mm;
            mm = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(200, 255))
                                             : 8'($urandom_range(0, 8));
            send(8'($urandom), 8'($urandom), 4'($urandom), 8'($urandom), mm,
                 16'($urandom_range(0, 200)), ($urandom_range(0, 3) == 0) ? 2 : 0, -1);
        end
        bp_mode = 0;

        // Reset in the middle of a body: abort, counters cleared.
        send(8'd5, 8'd6, 4'd0, 8'd1, 8'd4, 16'd0, 0, 1);
        rst = 1'b1;
        exp_q.delete();
        m_pkt = 48'd0;
        @(negedge clk);
        chk_idle_outputs("midrst", 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_rdy", 128'(req_rdy), 128'd1);
        send(8'd2, 8'd2, 4'd1, 8'd6, 8'd1, 16'd20, 0, -1);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("drain", 128'(exp_q.size()), 128'd0);
        chk("oversize_total", 128'(seen_ovs), 128'(exp_ovs));
        chk("framing_total", 128'(seen_frm), 128'(exp_frm));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/beehive_noc_hdr_builder.md
Name: beehive_noc_hdr_builder

Overview:
Parametrised header generator and framer for data-NoC messages; the next step beyond the fixed single-flit header definitions.
- Accepts a header request, fills the data NoC header fields: routing, msg_len, metadata_flits, packet_id (origin + running packet number) and a timestamp.
- Serialises the header over one or more flits, sized by NOC_DATA_W.
- Then forwards exactly the announced number of metadata + payload flits.
- Sits between a protocol engine's TX datapath and the NoC router port.

Parameters:
NOC_DATA_W, 512, NoC flit width in bits; must be a multiple of 64 and >= 64.
HDR_CORE_W, 220, width of the data NoC header core (84-bit base + 8 metadata_flits + 64 packet_id + 64 timestamp).
HDR_FLITS, ceil(HDR_CORE_W/NOC_DATA_W), header flits emitted (derived; 1 at 512, 2 at 128, 4 at 64).
SRC_FBITS, 4'b1000, src_fbits value placed in every header.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
src_x  in  8  this tile's x coord (quasi-static)
src_y  in  8  this tile's y coord (quasi-static)
req_val  in  1  header request valid
req_rdy  out  1  header request ready
req_dst_x  in  8  destination x
req_dst_y  in  8  destination y
req_dst_fbits  in  4  destination fbits
req_msg_type  in  8  message type
req_meta_flits  in  8  metadata flit count
req_payload_bytes  in  16  payload length in bytes
data_in_val  in  1  body flit valid
data_in_data  in  NOC_DATA_W  body flit
data_in_last  in  1  sender's last-flit marker
data_in_rdy  out  1  body flit ready
noc_out_val  out  1  NoC flit valid
noc_out_data  out  NOC_DATA_W  NoC flit
noc_out_rdy  in  1  NoC flit ready
err_oversize  out  1  one-cycle pulse: request dropped, msg_len > 255
err_framing  out  1  one-cycle pulse: data_in_last mismatched body count

Behaviour:
- Reset values: all outputs 0. State=IDLE. packet_num=0, timestamp counter=0.
- A transfer occurs when val&rdy are both high at a clk edge.
- Timestamp: free-running 64-bit counter, +1 per cycle, wraps. packet_num: 48-bit counter, wraps.
- Arithmetic:
  - BPF=NOC_DATA_W/8.
  - payload_flits=ceil(req_payload_bytes/BPF); 0 bytes gives 0 flits.
  - body=req_meta_flits+payload_flits, computed in 17 bits.
  - msg_len=HDR_FLITS-1+body. msg_len counts flits after the first flit.
- IDLE: req_rdy=1, data_in_rdy=0, noc_out_val=0. On request handshake:
  - If msg_len>255: pulse err_oversize next cycle. No flits emitted. packet_num not incremented. Stay IDLE.
  - Otherwise latch the header and go to HDR with hdr_idx=0.
  - Latched header fields: dst_chip_id=0, src_chip_id=0; dst fields from req; msg_len[7:0]; msg_type; src_x, src_y, SRC_FBITS; metadata_flits=req_meta_flits; packet_id={src_x,src_y,packet_num}; timestamp=counter value at the handshake cycle.
  - packet_num increments on the same edge.
- Header image: the 220-bit core left-justified in an HDR_FLITS*NOC_DATA_W vector, zero padding in the LSBs. Flit 0 carries the most significant NOC_DATA_W bits.
- HDR: noc_out_val=1, noc_out_data=header slice[hdr_idx], registered (no combinational path from req inputs). On each noc_out handshake hdr_idx++. After slice HDR_FLITS-1: go to BODY if body>0, else IDLE.
- BODY: combinational pass-through. noc_out_val=data_in_val, noc_out_data=data_in_data, data_in_rdy=noc_out_rdy. Body counter decrements per handshake.
  - On the final counted flit go to IDLE.
  - data_in_last is checked on every body handshake. Mismatch (last=1 early, or last=0 on the final flit) pulses err_framing next cycle. The flit count is never altered by data_in_last.
- req_rdy=0 outside IDLE; no request overlap. noc_out_val is held with stable data until noc_out_rdy (no retraction).
- Reset mid-message: aborts immediately to IDLE and clears counters. Any partial NoC message is the system's responsibility.

Test Plan:
- NOC_DATA_W=512, req dst(2,3) type 3, meta 1, payload 100 B, src(0,0) -> 1 header flit with msg_len=3, metadata_flits=1, packet_num=0; then 3 body flits; last marked on the 3rd gives no error.
- NOC_DATA_W=128, meta 0, payload 0 -> 2 header flits, msg_len=1, flit1 low 36 bits zero; return to IDLE; second request carries packet_num=1.
- Backpressure: noc_out_rdy toggled 1-0-1 on each flit -> data stable while stalled; no flit lost or duplicated; timestamp equals counter at req handshake.
- NOC_DATA_W=64, payload 65535 B -> msg_len>255: err_oversize pulses once, no noc_out_val, next request still gets packet_num=0.
- data_in_last asserted on the 1st of 3 body flits -> err_framing pulses once, all 3 flits still forwarded.
- rst asserted mid-BODY -> next cycle all outputs 0, state IDLE, next header has packet_num=0.
